// File: rtl/bram_pkg.sv
// Shared types and helpers for the bram_sdp_init block RAM.
// merge_be works on words up to BRAM_MAX_DW bits / BRAM_MAX_NB lanes;
// callers zero-extend their operands and truncate the result.
package bram_pkg;

    typedef enum logic {BRAM_IDLE, BRAM_CLEAR} bram_state_e;

    localparam int BRAM_MAX_DW = 256;
    localparam int BRAM_MAX_NB = 32;

    function automatic int bram_num_bytes(input int dw, input int bw);
        return dw / bw;
    endfunction

    // Lane merge: lanes with be set take new_word, the rest keep old_word.
    function automatic logic [BRAM_MAX_DW-1:0] merge_be(
        input logic [BRAM_MAX_DW-1:0] old_word,
        input logic [BRAM_MAX_DW-1:0] new_word,
        input logic [BRAM_MAX_NB-1:0] be,
        input int                     bw
    );
        logic [BRAM_MAX_DW-1:0] res;
        res = old_word;
        for (int k = 0; k < BRAM_MAX_DW; k++) begin
            if ((k / bw) < BRAM_MAX_NB) begin
                if (be[5'(k / bw)]) begin
                    res[8'(k)] = new_word[8'(k)];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bram_sdp_init_seq.sv
// Clear sequencer for bram_sdp_init: walks clr_addr over every word once,
// after reset or on an init_req seen in IDLE. All outputs are registered.
//
//  state      | meaning
//  BRAM_CLEAR | writing INIT_VALUE to clr_addr, one word per cycle
//  BRAM_IDLE  | memory available to the user ports
module bram_init_seq
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  init_req,
    output logic                  init_busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    bram_state_e state;

    // Clear FSM; exits on the cycle that writes the last address so it never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= BRAM_CLEAR;
            clr_addr  <= '0;
            init_busy <= 1'b1;
            clr_we    <= 1'b1;
        end else begin
            case (state)
                BRAM_CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state     <= BRAM_IDLE;
                        clr_addr  <= '0;
                        init_busy <= 1'b0;
                        clr_we    <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: begin
                    if (init_req) begin
                        state     <= BRAM_CLEAR;
                        clr_addr  <= '0;
                        init_busy <= 1'b1;
                        clr_we    <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/bram_sdp_init.sv
// Simple-dual-port block RAM with byte-enable writes, write-first collision
// bypass on the read port and a hardware clear sequencer.
// Optional macro BRAM_OUTREG_EN adds an output register (read latency 2).
// DATA_WIDTH must not exceed bram_pkg::BRAM_MAX_DW.
module bram_sdp_init
    import bram_pkg::*;
#(
    parameter int                        ADDR_WIDTH = 6,
    parameter int                        DATA_WIDTH = 32,
    parameter int                        BYTE_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]     INIT_VALUE = '0,
    localparam int                       NUM_BYTES  = bram_num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  init_req,
    output logic                  init_busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_BYTES-1:0]  wr_be,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_go;
    logic                  rd_go;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_valid_s1;
    logic [DATA_WIDTH-1:0] dout_s1;

    bram_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_seq (
        .clock     (clock),
        .reset     (reset),
        .init_req  (init_req),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign wr_go = wr_en & ~init_busy;
    assign rd_go = rd_en & ~init_busy;

    // Read word with write-first bypass of the lanes being written this cycle.
    always_comb begin
        rd_word = mem[rd_addr];
        if (wr_go && (wr_addr == rd_addr)) begin
            rd_word = DATA_WIDTH'(merge_be(BRAM_MAX_DW'(mem[rd_addr]),
                                           BRAM_MAX_DW'(din),
                                           BRAM_MAX_NB'(wr_be),
                                           BYTE_WIDTH));
        end
    end

    // Storage: clear writes take priority over user writes (users are gated off anyway).
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_addr] <= INIT_VALUE;
        end else if (wr_go) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read stage: capture on an accepted read, otherwise hold dout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_valid_s1 <= 1'b0;
            dout_s1     <= '0;
        end else begin
            rd_valid_s1 <= rd_go;
            if (rd_go) begin
                dout_s1 <= rd_word;
            end
        end
    end

`ifdef BRAM_OUTREG_EN
    logic                  rd_valid_s2;
    logic [DATA_WIDTH-1:0] dout_s2;

    // Output register: forwards stage 1 only when it carries a valid read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_valid_s2 <= 1'b0;
            dout_s2     <= '0;
        end else begin
            rd_valid_s2 <= rd_valid_s1;
            if (rd_valid_s1) begin
                dout_s2 <= dout_s1;
            end
        end
    end

    assign rd_valid = rd_valid_s2;
    assign dout     = dout_s2;
`else
    assign rd_valid = rd_valid_s1;
    assign dout     = dout_s1;
`endif

endmodule

// File: tb/tb_bram_sdp_init.sv
// Self-checking bench for bram_sdp_init (ADDR_WIDTH=4, DATA_WIDTH=32).
module tb_bram_sdp_init;

    localparam int          AW    = 4;
    localparam int          DW    = 32;
    localparam int          DEPTH = 16;
    localparam logic [31:0] INIT  = 32'hA5A5_0F0F;
`ifdef BRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          init_req = 1'b0;
    logic          init_busy;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [3:0]    wr_be = '0;
    logic [DW-1:0] din = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_valid;
    logic [DW-1:0] dout;

    int n_checks = 0;
    int n_fails  = 0;
    bit checking = 1'b0;

    bram_sdp_init #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BYTE_WIDTH (8),
        .INIT_VALUE (INIT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .init_req  (init_req),
        .init_busy (init_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_be     (wr_be),
        .din       (din),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .dout      (dout)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [DEPTH];
    int          busy_left = DEPTH;
    logic        p_valid = 1'b0;
    logic [31:0] p_data = '0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_dout = '0;
    logic        nv;
    logic [31:0] nd;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_left = DEPTH;
            p_valid   = 1'b0;
            p_data    = '0;
            exp_valid = 1'b0;
            exp_dout  = '0;
        end else begin
            nv = 1'b0;
            nd = '0;
            if (busy_left > 0) begin
                m_mem[DEPTH - busy_left] = INIT;
                busy_left--;
            end else begin
                if (rd_en) begin
                    nv = 1'b1;
                    nd = m_mem[rd_addr];
                    if (wr_en && wr_addr == rd_addr)
                        for (int i = 0; i < 4; i++)
                            if (wr_be[i]) nd[i*8 +: 8] = din[i*8 +: 8];
                end
                if (wr_en)
                    for (int i = 0; i < 4; i++)
                        if (wr_be[i]) m_mem[wr_addr][i*8 +: 8] = din[i*8 +: 8];
                if (init_req) busy_left = DEPTH;
            end
            if (LAT == 1) begin
                exp_valid = nv;
                if (nv) exp_dout = nd;
            end else begin
                exp_valid = p_valid;
                if (p_valid) exp_dout = p_data;
                p_valid = nv;
                if (nv) p_data = nd;
            end
        end
    end

    // Every-cycle comparison against the model, just after the falling edge.
    always @(negedge clock) begin
        #1;
        if (checking) begin
            check("model_init_busy", {31'b0, init_busy}, {31'b0, busy_left > 0});
            check("model_rd_valid", {31'b0, rd_valid}, {31'b0, exp_valid});
            check("model_dout", dout, exp_dout);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        init_req = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_be    = '0;
    endtask

    task automatic count_busy(input bit noisy, output int cnt);
        cnt = 0;
        while (init_busy === 1'b1 && cnt < 100) begin
            if (noisy) begin
                rd_en    = 1'($urandom_range(0, 1));
                rd_addr  = 4'($urandom);
                wr_en    = 1'($urandom_range(0, 1));
                wr_addr  = 4'($urandom);
                wr_be    = 4'($urandom);
                din      = $urandom;
                init_req = 1'($urandom_range(0, 1));
            end
            cnt++;
            @(negedge clock);
        end
        idle_inputs();
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; din = d; wr_be = be;
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
        rd_en = 1'b1; rd_addr = a;
        @(negedge clock);
        idle_inputs();
        repeat (LAT - 1) @(negedge clock);
        check({name, "_valid"}, {31'b0, rd_valid}, 32'd1);
        check(name, dout, exp);
    endtask

    task automatic pulse_init();
        init_req = 1'b1;
        @(negedge clock);
        init_req = 1'b0;
    endtask

    int cnt;

    initial begin
        idle_inputs();
        repeat (3) @(negedge clock);
        check("reset_busy", {31'b0, init_busy}, 32'd1);
        check("reset_valid", {31'b0, rd_valid}, 32'd0);
        check("reset_dout", dout, 32'd0);
        checking = 1'b1;
        reset = 1'b0;

        // 1: power-on clear length and contents
        count_busy(1'b0, cnt);
        check("clear_len_reset", cnt, 32'd16);
        for (int a = 0; a < DEPTH; a++) read_check("read_init", 4'(a), INIT);

        // 2: partial byte-enable overwrite
        do_write(4'd3, 32'hDEADBEEF, 4'hF);
        do_write(4'd3, 32'h11223344, 4'b0101);
        read_check("be_merge", 4'd3, 32'hDE22BE44);

        // 3: same-cycle collision, write-first per lane
        do_write(4'd5, 32'h01020304, 4'hF);
        wr_en = 1'b1; wr_addr = 4'd5; din = 32'hAABBCCDD; wr_be = 4'b1100;
        rd_en = 1'b1; rd_addr = 4'd5;
        @(negedge clock);
        idle_inputs();
        repeat (LAT - 1) @(negedge clock);
        check("collision", dout, 32'hAABB0304);
        read_check("after_collision", 4'd5, 32'hAABB0304);

        // 4: reset at clear cycle 7 restarts; noise during clear is ignored
        pulse_init();
        repeat (6) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        count_busy(1'b1, cnt);
        check("clear_len_restart", cnt, 32'd16);
        for (int a = 0; a < DEPTH; a++) read_check("read_after_restart", 4'(a), INIT);

        // 5: fill with 5 then clear on request
        for (int a = 0; a < DEPTH; a++) do_write(4'(a), 32'h5, 4'hF);
        read_check("fill_5", 4'd9, 32'h5);
        pulse_init();
        count_busy(1'b0, cnt);
        check("clear_len_req", cnt, 32'd16);
        for (int a = 0; a < DEPTH; a++) read_check("read_after_req", 4'(a), INIT);

        // 6: back-to-back reads then a gap
        do_write(4'd1, 32'h1111_0001, 4'hF);
        do_write(4'd2, 32'h2222_0002, 4'hF);
        do_write(4'd3, 32'h3333_0003, 4'hF);
        for (int a = 1; a <= 3; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            @(negedge clock);
        end
        idle_inputs();
        repeat (LAT) @(negedge clock);
        check("gap_valid", {31'b0, rd_valid}, 32'd0);
        check("gap_hold", dout, 32'h3333_0003);

        // random traffic with collisions and occasional clears
        for (int c = 0; c < 600; c++) begin
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = 4'($urandom);
            wr_be    = 4'($urandom);
            din      = $urandom;
            rd_en    = ($urandom_range(0, 9) < 6);
            rd_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
            init_req = ($urandom_range(0, 149) == 0);
            @(negedge clock);
        end
        idle_inputs();
        count_busy(1'b0, cnt);
        check("final_idle", {31'b0, init_busy}, 32'd0);
        repeat (3) @(negedge clock);
        checking = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
